// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - instruction sequencer: decodes a 9-bit word into multi-cycle control strobes
module ctrl_seq #(
  parameter int RW      = 3,
  parameter int JW      = 8,
  parameter int MEM_LAT = 2,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [8:0]    mach_code,
  output logic [2:0]    Aluop,
  output logic [RW-1:0] Ra,
  output logic [RW-1:0] Rb,
  output logic [RW-1:0] Wd,
  output logic [JW-1:0] Jptr,
  output logic [4:0]    LdcVal,
  output logic          WenR,
  output logic          WenD,
  output logic          RenD,
  output logic          MemToReg,
  output logic          Jen,
  output logic          Ldcen,
  output logic          stall,
  output logic          Done,
  output logic [CW-1:0] retire_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, HALT} state_t;

  localparam logic [3:0] MEM_LEN = 4'(MEM_LAT);

  state_t        state, state_n;
  logic [8:0]    ir;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    len;
  logic          done_r;
  logic [CW-1:0] retire_r;
  logic          accept, halt_in, active, last;
  logic          is_nop, is_r, is_br, is_ldr, is_ldc, is_st, is_mv;

  assign accept  = (state == IDLE) && instr_valid;
  assign halt_in = (mach_code == 9'h0FF);
  assign active  = (state == EXEC) || (state == WAIT);
  // cnt holds the number of cycles still to run, including the current WAIT cycle
  assign last    = ((state == EXEC) && (len == 4'd1)) || ((state == WAIT) && (cnt == 4'd1));

  always_comb begin
    is_nop = 1'b0; is_r = 1'b0; is_br = 1'b0; is_ldr = 1'b0;
    is_ldc = 1'b0; is_st = 1'b0; is_mv = 1'b0;
    if (!ir[8]) begin
      if (ir[7:5] == 3'b110) is_nop = 1'b1;
      else                   is_r   = 1'b1;
    end else begin
      case (ir[7:6])
        2'b00:   is_br = 1'b1;
        2'b10:   begin is_ldc = ir[0]; is_ldr = !ir[0]; end
        2'b01:   is_st = 1'b1;
        default: is_mv = 1'b1;
      endcase
    end
    len = 4'd1;
    if (is_nop)          len = 4'd2;
    if (is_ldr || is_st) len = MEM_LEN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      cnt      <= '0;
      done_r   <= 1'b0;
      retire_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) ir <= mach_code;
      if (accept && halt_in) done_r <= 1'b1;
      else if ((state == HALT) && start) done_r <= 1'b0;
      if (active && last) retire_r <= retire_r + CW'(1);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (instr_valid) state_n = halt_in ? HALT : EXEC;
      EXEC: begin
        cnt_n   = len - 4'd1;
        state_n = last ? IDLE : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (last) state_n = IDLE;
      end
      HALT: if (start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Aluop    = '0;
    Ra       = '0;
    Rb       = '0;
    Wd       = '0;
    Jptr     = '0;
    LdcVal   = '0;
    WenR     = 1'b0;
    WenD     = 1'b0;
    RenD     = 1'b0;
    MemToReg = 1'b1;
    Jen      = 1'b0;
    Ldcen    = 1'b0;
    stall    = active && !last;
    if (active) begin
      if (is_r) begin
        Aluop = ir[7:5]; Ra = RW'(ir[4:3]); Rb = RW'(ir[2:0]); Wd = RW'(ir[2:0]);
      end
      if (is_br)  Jptr = JW'(ir[5:0]);
      if (is_ldr) begin
        Wd = RW'(ir[5:3]); Ra = RW'(6); RenD = 1'b1; MemToReg = 1'b0;
      end
      if (is_ldc) begin
        LdcVal = ir[5:1]; Wd = RW'(6);
      end
      if (is_st) begin
        Ra = RW'(7); Rb = RW'(ir[5:3]);
      end
      if (is_mv) begin
        Aluop = 3'b111; Ra = RW'(ir[5:3]); Wd = RW'(ir[2:0]);
      end
      WenR  = last && (is_r || is_mv || is_ldr || is_ldc);
      WenD  = last && is_st;
      Jen   = last && is_br;
      Ldcen = last && is_ldc;
    end
  end

  assign instr_ready = (state == IDLE);
  assign Done        = done_r;
  assign retire_cnt  = retire_r;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed and random instruction streams against a decode-table reference model
module tb_ctrl_seq;

  localparam int RW  = 3;
  localparam int JW  = 8;
  localparam int ML  = 3;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [8:0]    mach_code = '0;
  logic [2:0]    Aluop;
  logic [RW-1:0] Ra, Rb, Wd;
  logic [JW-1:0] Jptr;
  logic [4:0]    LdcVal;
  logic          WenR, WenD, RenD, MemToReg, Jen, Ldcen, stall, Done;
  logic [CW-1:0] retire_cnt;

  int nvec = 0;
  int nerr = 0;
  int exp_ret = 0;

  typedef struct {
    int         len;
    bit         halt;
    logic [2:0] aluop, ra, rb, wd;
    logic [7:0] jptr;
    logic [4:0] ldc;
    bit         wenr, wend, jen, ldcen, rend;
  } exp_t;

  ctrl_seq #(.RW(RW), .JW(JW), .MEM_LAT(ML), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .mach_code(mach_code), .Aluop(Aluop), .Ra(Ra),
    .Rb(Rb), .Wd(Wd), .Jptr(Jptr), .LdcVal(LdcVal), .WenR(WenR), .WenD(WenD),
    .RenD(RenD), .MemToReg(MemToReg), .Jen(Jen), .Ldcen(Ldcen), .stall(stall),
    .Done(Done), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [8:0] c);
    exp_t e = '{default: 0};
    e.len = 1;
    casez (c)
      9'b0_1111_1111: e.halt = 1;
      9'b0_110?_????: e.len = 2;
      9'b0_????_????: begin e.aluop = c[7:5]; e.ra = {1'b0, c[4:3]}; e.rb = c[2:0]; e.wd = c[2:0]; e.wenr = 1; end
      9'b100_??????:  begin e.jptr = {2'b00, c[5:0]}; e.jen = 1; end
      9'b110_?????0:  begin e.wd = c[5:3]; e.ra = 3'd6; e.rend = 1; e.wenr = 1; e.len = ML; end
      9'b110_?????1:  begin e.ldc = c[5:1]; e.wd = 3'd6; e.wenr = 1; e.ldcen = 1; end
      9'b101_??????:  begin e.ra = 3'd7; e.rb = c[5:3]; e.wend = 1; e.len = ML; end
      default:        begin e.aluop = 3'd7; e.ra = c[5:3]; e.wd = c[2:0]; e.wenr = 1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input exp_t e, input bit act, input bit last, input bit rdy, input bit dn);
    chk("instr_ready", 32'(instr_ready), 32'(rdy));
    chk("Done",        32'(Done),        32'(dn));
    chk("Aluop",       32'(Aluop),       act ? 32'(e.aluop) : 0);
    chk("Ra",          32'(Ra),          act ? 32'(e.ra)    : 0);
    chk("Rb",          32'(Rb),          act ? 32'(e.rb)    : 0);
    chk("Wd",          32'(Wd),          act ? 32'(e.wd)    : 0);
    chk("Jptr",        32'(Jptr),        act ? 32'(e.jptr)  : 0);
    chk("LdcVal",      32'(LdcVal),      act ? 32'(e.ldc)   : 0);
    chk("RenD",        32'(RenD),        32'(act && e.rend));
    chk("MemToReg",    32'(MemToReg),    32'(!(act && e.rend)));
    chk("WenR",        32'(WenR),        32'(act && last && e.wenr));
    chk("WenD",        32'(WenD),        32'(act && last && e.wend));
    chk("Jen",         32'(Jen),         32'(act && last && e.jen));
    chk("Ldcen",       32'(Ldcen),       32'(act && last && e.ldcen));
    chk("stall",       32'(stall),       32'(act && !last));
    chk("retire_cnt",  32'(retire_cnt),  32'(exp_ret));
  endtask

  task automatic run_instr(input logic [8:0] code);
    exp_t e = model(code);
    exp_t z = '{default: 0};
    chk_all(z, 0, 0, 1, 0);
    mach_code   = code;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'($urandom_range(0, 1));
    mach_code   = 9'($urandom);
    if (e.halt) begin
      start = 1'b0;
      repeat (1 + $urandom_range(0, 2)) begin
        chk_all(z, 0, 0, 0, 1);
        @(posedge clk); #1;
        instr_valid = 1'($urandom_range(0, 1));
        mach_code   = 9'($urandom);
      end
      chk_all(z, 0, 0, 0, 1);
      start = 1'b1;
      instr_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      for (int c = 0; c < e.len; c++) begin
        start = 1'($urandom_range(0, 1));
        chk_all(e, 1, c == e.len - 1, 0, 0);
        @(posedge clk); #1;
        instr_valid = 1'($urandom_range(0, 1));
        mach_code   = 9'($urandom);
      end
      exp_ret = (exp_ret + 1) % (1 << CW);
      start = 1'b0;
    end
    instr_valid = 1'b0;
    chk_all(z, 0, 0, 1, 0);
  endtask

  initial begin
    exp_t z = '{default: 0};
    #3;
    chk_all(z, 0, 0, 1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_instr(9'b0_010_01_101);
    run_instr(9'b1_10_011_000);
    run_instr(9'b1_01_010_111);
    run_instr(9'b1_00_101010);
    run_instr(9'b0_1111_1111);
    run_instr(9'b0_110_1_0101);
    run_instr(9'b1_10_10101_1);
    run_instr(9'b1_11_100_011);
    run_instr(9'b0_111_11_110);

    for (int i = 0; i < 40; i++) run_instr(9'($urandom));

    mach_code   = 9'b1_01_110_001;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rst_store_exec_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    chk("rst_store_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_ret = 0;
    chk_all(z, 0, 0, 1, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_hold_WenD", 32'(WenD), 32'd0);
    end
    rst_n = 1'b1;
    run_instr(9'b1_00_000111);
    run_instr(9'b1_01_011_000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
